// File: rtl/cms_ctrl_sequencer_pkg.sv
// Shared constants and types for the CMS control-bus write sequencer.
package cms_ctrl_sequencer_pkg;

    localparam int CMS_ADDR_WIDTH = 8;
    localparam int CMS_DATA_WIDTH = 64;

    // CMS control register map
    localparam int ADDR_TRIGGER_TRACE_START_ADDRESS_ENABLED    = 0;
    localparam int ADDR_TRIGGER_TRACE_END_ADDRESS_ENABLED      = 1;
    localparam int ADDR_TRIGGER_TRACE_START_ADDRESS            = 2;
    localparam int ADDR_TRIGGER_TRACE_END_ADDRESS              = 3;
    localparam int ADDR_MONITORED_ADDRESS_RANGE_LOWER_ENABLED  = 4;
    localparam int ADDR_MONITORED_ADDRESS_RANGE_UPPER_ENABLED  = 5;
    localparam int ADDR_MONITORED_ADDRESS_RANGE_LOWER_BOUND    = 6;
    localparam int ADDR_MONITORED_ADDRESS_RANGE_UPPER_BOUND    = 7;
    localparam int ADDR_WFI_REACHED                            = 8;

    // Write sequencer phases: pop, present, strobe, keep the strobe low
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cms_ctrl_sequencer_if.sv
// Host command handshake: valid/ready with target address and write data.
interface cms_ctrl_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_ready
    );
endinterface

// File: rtl/cms_ctrl_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without an occupancy counter.
module cms_ctrl_cmd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointer covers them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Serialises host writes onto the CMS control bus. The CMS latches on the
// rising edge of ctrl_write_enable, so every write is presented a cycle
// ahead, strobed for one cycle and followed by a low gap.
module cms_ctrl_sequencer
    import cms_ctrl_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = CMS_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CMS_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 1,
    parameter int MAX_VALID_ADDR = ADDR_WFI_REACHED
) (
    input  logic                  clk,
    input  logic                  rst,
    cms_ctrl_sequencer_if.slave   cmd,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic [DATA_WIDTH-1:0] ctrl_wdata,
    output logic                  ctrl_write_enable,
    output logic                  busy,
    output logic [15:0]           write_count,
    output logic                  cmd_err
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_t                       state;
    seq_state_t                       next_state;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rdata;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             accept;
    logic                             addr_bad;
    logic                             push;
    logic                             pop;
    logic                             we_next;
    logic                             strobe_done;
    logic [GAP_W-1:0]                 gap_cnt;

    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign addr_bad = cmd.cmd_addr > ADDR_WIDTH'(MAX_VALID_ADDR);
    assign push     = accept && !addr_bad;

    assign cmd.cmd_ready = !fifo_full;
    assign busy          = !fifo_empty || (state != ST_IDLE);

    cms_ctrl_cmd_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd.cmd_addr, cmd.cmd_wdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state: one pass through SETUP/STROBE/HOLD per queued write
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_STROBE;
            ST_STROBE: next_state = ST_HOLD;
            ST_HOLD:   if (gap_cnt == '0) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Per-state actions feeding the registered outputs
    always_comb begin
        pop         = 1'b0;
        we_next     = 1'b0;
        strobe_done = 1'b0;
        case (state)
            ST_IDLE:   pop         = !fifo_empty;
            ST_SETUP:  we_next     = 1'b1;
            ST_STROBE: strobe_done = 1'b1;
            default:   ;
        endcase
    end

    // Registered bus, strobe count and gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_addr         <= '0;
            ctrl_wdata        <= '0;
            ctrl_write_enable <= 1'b0;
            write_count       <= '0;
            gap_cnt           <= '0;
        end else begin
            ctrl_write_enable <= we_next;
            if (pop) {ctrl_addr, ctrl_wdata} <= fifo_rdata;
            if (strobe_done) begin
                write_count <= write_count + 16'd1;
                gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
            end else if (state == ST_HOLD && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Sticky illegal-address flag; a new error beats a clear
    always_ff @(posedge clk) begin
        if (rst)                        cmd_err <= 1'b0;
        else if (accept && addr_bad)    cmd_err <= 1'b1;
        else if (err_clr)               cmd_err <= 1'b0;
    end
endmodule
